// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the FP compare scheduler.
//   EXTRA_BITS     : extra low-order mantissa bits carried on each operand
//   FCMP_*         : predicate select encodings (3 bits)
//   CMP_*          : bit positions within the raw compare vector
//   pred_sel()     : reduce a compare vector to the selected predicate bit
//   is_signaling() : predicates that raise invalid on an unordered compare
package fp_cmp_pkg;

  localparam int unsigned EXTRA_BITS = 0;

  localparam logic [2:0] FCMP_EQ    = 3'd0;
  localparam logic [2:0] FCMP_LT    = 3'd1;
  localparam logic [2:0] FCMP_LE    = 3'd2;
  localparam logic [2:0] FCMP_LTMAG = 3'd3;
  localparam logic [2:0] FCMP_UN    = 3'd4;
  localparam logic [2:0] FCMP_NE    = 3'd5;
  localparam logic [2:0] FCMP_GT    = 3'd6;
  localparam logic [2:0] FCMP_GE    = 3'd7;

  localparam int unsigned CMP_EQ    = 0;
  localparam int unsigned CMP_LT    = 1;
  localparam int unsigned CMP_LE    = 2;
  localparam int unsigned CMP_LTMAG = 3;
  localparam int unsigned CMP_UN    = 4;

  function automatic logic pred_sel(input logic [2:0] op, input logic [4:0] vec);
    logic res;
    case (op)
      FCMP_EQ:    res = vec[CMP_EQ];
      FCMP_LT:    res = vec[CMP_LT];
      FCMP_LE:    res = vec[CMP_LE];
      FCMP_LTMAG: res = vec[CMP_LTMAG];
      FCMP_UN:    res = vec[CMP_UN];
      FCMP_NE:    res = !vec[CMP_EQ];
      FCMP_GT:    res = !vec[CMP_LE] & !vec[CMP_UN];
      default:    res = (!vec[CMP_LT] | vec[CMP_EQ]) & !vec[CMP_UN];
    endcase
    return res;
  endfunction

  function automatic logic is_signaling(input logic [2:0] op);
    return (op == FCMP_LT) || (op == FCMP_LE) || (op == FCMP_GT) || (op == FCMP_GE);
  endfunction

endpackage

// File: rtl/fpCompare.sv
// Combinational IEEE compare of two FPWID(+EXTRA_BITS) operands.
//   a, b : operands (sign, exponent, mantissa[, extra bits])
//   o    : {un, ltmag, le, lt, eq}; +0 == -0, any NaN gives un=1, eq=lt=le=0
//   nan  : either operand is a NaN
//   nanx : either operand is a signaling NaN (quiet bit clear)
module fpCompare import fp_cmp_pkg::*; #(
  parameter int unsigned FPWID = 64
) (
  input  logic [FPWID+EXTRA_BITS-1:0] a,
  input  logic [FPWID+EXTRA_BITS-1:0] b,
  output logic [4:0]                  o,
  output logic                        nan,
  output logic                        nanx
);

  localparam int unsigned W  = FPWID + EXTRA_BITS;
  localparam int unsigned EW = (FPWID == 16) ? 5 : (FPWID == 32) ? 8 :
                               (FPWID == 128) ? 15 : 11;
  localparam int unsigned MW = W - 1 - EW;

  logic          sa, sb;
  logic [W-2:0]  mag_a, mag_b;
  logic          nan_a, nan_b, snan_a, snan_b;
  logic          both_zero, un, eq, lt, ltmag;

  assign sa    = a[W-1];
  assign sb    = b[W-1];
  assign mag_a = a[W-2:0];
  assign mag_b = b[W-2:0];

  assign nan_a  = (&a[W-2 -: EW]) & (|a[MW-1:0]);
  assign nan_b  = (&b[W-2 -: EW]) & (|b[MW-1:0]);
  assign snan_a = nan_a & !a[MW-1];
  assign snan_b = nan_b & !b[MW-1];

  assign both_zero = (mag_a == '0) && (mag_b == '0);
  assign un        = nan_a | nan_b;
  assign eq        = !un & (both_zero | (a == b));
  assign ltmag     = !un & (mag_a < mag_b);

  always_comb begin
    lt = 1'b0;
    if (!un && !both_zero) begin
      if (sa != sb) lt = sa;
      else if (sa)  lt = mag_a > mag_b;
      else          lt = mag_a < mag_b;
    end
  end

  assign o    = {un, ltmag, lt | eq, lt, eq};
  assign nan  = un;
  assign nanx = snan_a | snan_b;

endmodule

// File: rtl/fp_rr_arb.sv
// Round-robin arbiter with its own rotating pointer.
//   req_valid : per-requester request
//   advance   : downstream stage can take a request this cycle
//   grant     : one-hot grant, zero when nothing requested or advance=0
//   grant_id  : index of the winning requester (valid when accept=1)
//   accept    : a grant is being taken this cycle
module fp_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            accept
);

  logic [IDW-1:0] rr_ptr;
  logic           grant_any;
  int unsigned    idx;

  // Search upward from rr_ptr with wrap; first hit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign accept = grant_any & advance;

  always_comb begin
    grant = '0;
    if (accept) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= IDW'((32'(grant_id) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/fp_cmp_sched.sv
// Shares one fpCompare among NREQ requesters through a 2-stage pipeline.
//   req_valid/req_ready       : per-requester handshake, ready is one-hot or zero
//   req_a/req_b/req_op        : per-requester operands and predicate select
//   resp_valid/resp_ready     : single response channel with backpressure
//   resp_id/resp_bit/resp_vec : requester index, selected predicate, raw vector
//   inv_sticky/inv_clr        : sticky invalid flag and its synchronous clear
module fp_cmp_sched import fp_cmp_pkg::*; #(
  parameter int unsigned FPWID = 64,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*(FPWID+EXTRA_BITS)-1:0]  req_a,
  input  logic [NREQ*(FPWID+EXTRA_BITS)-1:0]  req_b,
  input  logic [NREQ*3-1:0]                   req_op,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [IDW-1:0]                      resp_id,
  output logic                                resp_bit,
  output logic [4:0]                          resp_vec,
  output logic                                inv_sticky,
  input  logic                                inv_clr
);

  localparam int unsigned W = FPWID + EXTRA_BITS;

  logic           advance1, advance2, hs;
  logic [IDW-1:0] grant_id;

  logic           s1_valid;
  logic [W-1:0]   s1_a, s1_b;
  logic [2:0]     s1_op;
  logic [IDW-1:0] s1_id;

  logic           s2_valid;
  logic [IDW-1:0] s2_id;
  logic [4:0]     s2_vec;
  logic           s2_bit;

  logic [4:0]     cmp_vec;
  logic           sel_bit, inv_set;
  logic           unused_nan, unused_nanx;

  // A full pipeline stalls as a unit so resumption leaves no bubble.
  assign advance2 = !s2_valid | resp_ready;
  assign advance1 = !s1_valid | advance2;

  fp_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .advance   (advance1),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .accept    (hs)
  );

  fpCompare #(
    .FPWID (FPWID)
  ) u_cmp (
    .a    (s1_a),
    .b    (s1_b),
    .o    (cmp_vec),
    .nan  (unused_nan),
    .nanx (unused_nanx)
  );

  assign sel_bit = pred_sel(s1_op, cmp_vec);
  assign inv_set = advance2 & s1_valid & cmp_vec[CMP_UN] & is_signaling(s1_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_id      <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= '0;
      s2_vec     <= '0;
      s2_bit     <= 1'b0;
      inv_sticky <= 1'b0;
    end else begin
      if (advance1) begin
        s1_valid <= hs;
        if (hs) begin
          s1_a  <= req_a[32'(grant_id)*W +: W];
          s1_b  <= req_b[32'(grant_id)*W +: W];
          s1_op <= req_op[32'(grant_id)*3 +: 3];
          s1_id <= grant_id;
        end
      end
      if (advance2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id  <= s1_id;
          s2_vec <= cmp_vec;
          s2_bit <= sel_bit;
        end
      end
      // Set beats clear when both land in the same cycle.
      if (inv_set)      inv_sticky <= 1'b1;
      else if (inv_clr) inv_sticky <= 1'b0;
    end
  end

  assign resp_valid = s2_valid;
  assign resp_id    = s2_id;
  assign resp_bit   = s2_bit;
  assign resp_vec   = s2_vec;

endmodule

// File: tb/tb_fp_cmp_sched.sv
module tb_fp_cmp_sched;
  import fp_cmp_pkg::*;

  localparam int unsigned FPWID = 64;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 3;
  localparam int unsigned W     = FPWID + EXTRA_BITS;

  localparam logic [63:0] P0   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] N0   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] P1   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] N1   = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] P2   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] N2   = 64'hC000_0000_0000_0000;
  localparam logic [63:0] P3   = 64'h4008_0000_0000_0000;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic [NREQ*3-1:0]   req_op;
  logic                resp_valid, resp_ready, resp_bit, inv_sticky, inv_clr;
  logic [IDW-1:0]      resp_id;
  logic [4:0]          resp_vec;

  fp_cmp_sched #(
    .FPWID (FPWID),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_bit   (resp_bit),
    .resp_vec   (resp_vec),
    .inv_sticky (inv_sticky),
    .inv_clr    (inv_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic           bitv;
    logic [4:0]     vec;
    logic [4:0]     mask;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   resp_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   last_hs_cyc = 0;

  // Per-requester vectors for the streaming phases (hand-computed results).
  logic [63:0] tab_a   [NREQ] = '{P0, P3, N2, P1};
  logic [63:0] tab_b   [NREQ] = '{N0, N1, P1, P1};
  logic [2:0]  tab_op  [NREQ] = '{FCMP_EQ, FCMP_GT, FCMP_LE, FCMP_NE};
  logic        tab_bit [NREQ] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [4:0]  tab_vec [NREQ] = '{5'b00101, 5'b00000, 5'b00110, 5'b00101};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (resp_valid && resp_ready) begin
        resp_log.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got response id=%0d, required none", resp_id);
        end else begin
          e = sb.pop_front();
          check("resp_id", 32'(resp_id), 32'(e.id));
          check("resp_bit", 32'(resp_bit), 32'(e.bitv));
          check("resp_vec", 32'(resp_vec & e.mask), 32'(e.vec & e.mask));
          if (e.cyc >= 0) check("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op);
    logic [W-1:0] ta, tbv;
    ta  = '0;
    tbv = '0;
    ta[W-1 -: FPWID]  = a;
    tbv[W-1 -: FPWID] = b;
    req_a[i*W +: W]   = ta;
    req_b[i*W +: W]   = tbv;
    req_op[i*3 +: 3]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic push(input int id, input logic bitv, input logic [4:0] vec,
                      input logic [4:0] mask, input int c);
    exp_t e;
    e.id   = IDW'(id);
    e.bitv = bitv;
    e.vec  = vec;
    e.mask = mask;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Returns #1 after the posedge that accepts handshake number 'target'.
  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (hs_cnt < target && n < 100);
    if (hs_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: handshakes got %0d required %0d", name, hs_cnt, target);
    end
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: pending responses got %0d required 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int base, lb;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b1;
    inv_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_bit", 32'(resp_bit), 32'd0);
    check("rst_resp_vec", 32'(resp_vec), 32'd0);
    check("rst_inv_sticky", 32'(inv_sticky), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, latency 2.
    @(posedge clk);
    #1;
    set_req(2, P1, P2, FCMP_LT);
    base = hs_cnt;
    wait_hs(base + 1, "single_hs");
    push(2, 1'b1, 5'b00110, 5'b10111, last_hs_cyc + 2);
    req_valid = '0;
    drain("single_drain");

    // All four streaming, round robin from 0, one response per cycle.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, tab_a[i], tab_b[i], tab_op[i]);
    for (int k = 0; k < 8; k++) push(k % NREQ, tab_bit[k % NREQ], tab_vec[k % NREQ], 5'b11111, -1);
    lb = resp_log.size();
    base = hs_cnt;
    wait_hs(base + 8, "stream_hs");
    req_valid = '0;
    drain("stream_drain");
    if (resp_log.size() >= lb + 8) check("stream_span", 32'(resp_log[lb+7] - resp_log[lb]), 32'd7);
    else check("stream_count", 32'(resp_log.size() - lb), 32'd8);

    // Backpressure with full pipeline.
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, tab_a[i], tab_b[i], tab_op[i]);
    for (int k = 0; k < 6; k++) push(k % NREQ, tab_bit[k % NREQ], tab_vec[k % NREQ], 5'b11111, -1);
    base = hs_cnt;
    wait_hs(base + 2, "bp_fill");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_id", 32'(resp_id), 32'd0);
      check("bp_resp_vec", 32'(resp_vec), 32'(tab_vec[0]));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    check("bp_hs_hold", 32'(hs_cnt), 32'(base + 2));
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_hs(base + 6, "bp_resume");
    req_valid = '0;
    drain("bp_drain");

    // NaN: signaling predicate sets the flag, UN does not.
    set_req(1, QNAN, P1, FCMP_GE);
    push(1, 1'b0, 5'b10000, 5'b11111, -1);
    base = hs_cnt;
    wait_hs(base + 1, "nan_ge_hs");
    req_valid = '0;
    drain("nan_ge_drain");
    check("inv_set_ge", 32'(inv_sticky), 32'd1);
    inv_clr = 1'b1;
    @(posedge clk);
    #1 inv_clr = 1'b0;
    @(negedge clk);
    check("inv_clr", 32'(inv_sticky), 32'd0);
    @(posedge clk);
    #1;
    set_req(1, QNAN, P1, FCMP_UN);
    push(1, 1'b1, 5'b10000, 5'b11111, -1);
    base = hs_cnt;
    wait_hs(base + 1, "nan_un_hs");
    req_valid = '0;
    drain("nan_un_drain");
    check("inv_un_noset", 32'(inv_sticky), 32'd0);

    // Clear in the same cycle as a set: set wins.
    set_req(3, P1, QNAN, FCMP_LT);
    push(3, 1'b0, 5'b10000, 5'b11111, -1);
    base = hs_cnt;
    wait_hs(base + 1, "prio_hs");
    req_valid = '0;
    inv_clr = 1'b1;
    @(posedge clk);
    #1 inv_clr = 1'b0;
    @(negedge clk);
    check("inv_set_wins", 32'(inv_sticky), 32'd1);
    @(posedge clk);
    #1 inv_clr = 1'b1;
    @(posedge clk);
    #1 inv_clr = 1'b0;
    @(negedge clk);
    check("inv_clr_after", 32'(inv_sticky), 32'd0);
    drain("prio_drain");

    // Reset with both stages full: nothing emitted, pointer back to 0.
    resp_ready = 1'b0;
    set_req(1, P1, P2, FCMP_LT);
    set_req(2, P1, P2, FCMP_LT);
    base = hs_cnt;
    wait_hs(base + 2, "rst_fill");
    req_valid = '0;
    @(negedge clk);
    check("rst_pre_full", 32'(resp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    set_req(1, P3, N1, FCMP_GT);
    set_req(3, P1, P1, FCMP_NE);
    push(1, 1'b1, 5'b00000, 5'b11111, -1);
    push(3, 1'b0, 5'b00101, 5'b11111, -1);
    @(negedge clk);
    check("rst_first_grant", 32'(req_ready), 32'b0010);
    base = hs_cnt;
    wait_hs(base + 2, "rst_after_hs");
    req_valid = '0;
    drain("rst_after_drain");

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
